alu_issue_scheduler: RTL and testbench

Age-ordered issue scheduler for the two-ALU integer cluster. It sits beside the ALU reservation station and tracks the allocation order of every RS entry in an age matrix. Each cycle it selects the oldest and second-oldest operand-ready entries for ALU1 and ALU2, and returns a grant vector so the RS frees those slots. Selected indices are registered toward the ALU operand-read stage.

---
 rtl/alu_issue_scheduler.sv | 125 ++++++++++++
 tb/tb_alu_issue_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_scheduler.sv
// Age-ordered issue scheduler for the two-ALU integer cluster: picks the oldest and
// second-oldest ready RS entries each cycle via an age matrix and registers the issue.
module alu_issue_scheduler #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned IDX_W       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               alloc_valid,
  input  logic [2*IDX_W-1:0]       alloc_idx,
  input  logic [NUM_ENTRIES-1:0]   entry_ready,
  input  logic                     alu1_rdy,
  input  logic                     alu2_rdy,
  output logic [NUM_ENTRIES-1:0]   grant_vec,
  output logic [1:0]               issue_valid,
  output logic [2*IDX_W-1:0]       issue_idx,
  output logic [15:0]              stall_cnt,
  output logic                     proto_err
);

  localparam int unsigned N  = NUM_ENTRIES;
  localparam int unsigned CW = $clog2(NUM_ENTRIES) + 1;

  logic [N-1:0]     occ;
  logic [N-1:0]     older     [N];
  logic [N-1:0]     older_nxt [N];
  logic [N-1:0]     elig, oldest, second, g1, g2;
  logic [N-1:0]     alloc_mask, survive;
  logic [IDX_W-1:0] a0, a1;
  logic [CW-1:0]    cnt;
  logic             acc0, acc1, viol;

  function automatic logic [IDX_W-1:0] enc(input logic [N-1:0] v);
    enc = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) enc = IDX_W'(i);
  endfunction

  assign a0   = alloc_idx[IDX_W-1:0];
  assign a1   = alloc_idx[2*IDX_W-1:IDX_W];
  assign elig = occ & entry_ready;

  // Rank each eligible entry by how many eligible entries are older than it.
  always_comb begin : pick
    oldest = '0;
    second = '0;
    cnt    = '0;
    for (int i = 0; i < N; i++) begin
      cnt = '0;
      for (int j = 0; j < N; j++)
        if (j != i && elig[j] && older[j][i]) cnt = cnt + CW'(1);
      oldest[i] = elig[i] && (cnt == CW'(0));
      second[i] = elig[i] && (cnt == CW'(1));
    end
  end

  always_comb begin : alu_assign
    g1 = '0;
    g2 = '0;
    if (!flush) begin
      if (alu1_rdy) begin
        g1 = oldest;
        if (alu2_rdy) g2 = second;
      end else if (alu2_rdy) begin
        g2 = oldest;
      end
    end
  end

  assign grant_vec = g1 | g2;

  // A granted entry may be reallocated in the same cycle; anything else occupied is a violation.
  always_comb begin : alloc_chk
    acc0 = alloc_valid[0] && !(occ[a0] && !grant_vec[a0]);
    acc1 = alloc_valid[1] && !(occ[a1] && !grant_vec[a1]) &&
           !(alloc_valid[0] && (a0 == a1));
    viol = (alloc_valid[0] && !acc0) || (alloc_valid[1] && !acc1);
    alloc_mask = '0;
    if (acc0) alloc_mask[a0] = 1'b1;
    if (acc1) alloc_mask[a1] = 1'b1;
  end

  assign survive = occ & ~grant_vec & ~alloc_mask;

  // New entries become younger than every survivor; slot 0 is older than slot 1.
  always_comb begin : age_upd
    for (int i = 0; i < N; i++) older_nxt[i] = older[i];
    for (int k = 0; k < N; k++) begin
      if (alloc_mask[k]) begin
        older_nxt[k] = '0;
        for (int j = 0; j < N; j++) older_nxt[j][k] = survive[j];
      end
    end
    if (acc0 && acc1) begin
      older_nxt[a0][a1] = 1'b1;
      older_nxt[a1][a0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : state_q
    if (reset) begin
      occ         <= '0;
      for (int i = 0; i < N; i++) older[i] <= '0;
      issue_valid <= '0;
      issue_idx   <= '0;
      stall_cnt   <= '0;
      proto_err   <= 1'b0;
    end else if (flush) begin
      occ         <= '0;
      for (int i = 0; i < N; i++) older[i] <= '0;
      issue_valid <= '0;
    end else begin
      occ <= survive | alloc_mask;
      for (int i = 0; i < N; i++) older[i] <= older_nxt[i];
      issue_valid <= {|g2, |g1};
      if (|g1) issue_idx[IDX_W-1:0]       <= enc(g1);
      if (|g2) issue_idx[2*IDX_W-1:IDX_W] <= enc(g2);
      if (viol) proto_err <= 1'b1;
      if (|elig && (grant_vec == '0) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: an age-ordered list model predicts grants,
// issues, stall count and protocol errors under directed and random stimulus.
module tb_alu_issue_scheduler;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic [1:0]      alloc_valid;
  logic [2*IW-1:0] alloc_idx;
  logic [N-1:0]    entry_ready;
  logic            alu1_rdy, alu2_rdy;
  logic [N-1:0]    grant_vec;
  logic [1:0]      issue_valid;
  logic [2*IW-1:0] issue_idx;
  logic [15:0]     stall_cnt;
  logic            proto_err;

  alu_issue_scheduler #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .entry_ready(entry_ready),
    .alu1_rdy(alu1_rdy), .alu2_rdy(alu2_rdy), .grant_vec(grant_vec),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .stall_cnt(stall_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: occupied entries, oldest first.
  int  age_q[$];
  int  exp1_q[$];
  int  exp2_q[$];
  int  m_stall = 0;
  bit  m_err   = 1'b0;
  logic [N-1:0] last_grant;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  function automatic bit held(input int e);
    foreach (age_q[k]) if (age_q[k] == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void drop(input int e);
    foreach (age_q[k]) if (age_q[k] == e) begin age_q.delete(k); return; end
  endfunction

  function automatic void model_grant(input logic [N-1:0] rdy, input logic r1, input logic r2,
                                      input logic fl, output logic [N-1:0] g,
                                      output int e1, output int e2);
    int c[$];
    g = '0; e1 = -1; e2 = -1;
    foreach (age_q[k]) if (rdy[age_q[k]]) c.push_back(age_q[k]);
    if (!fl) begin
      if (r1 && c.size() > 0) e1 = c[0];
      if (r2) begin
        if (r1) begin
          if (c.size() > 1) e2 = c[1];
        end else if (c.size() > 0) begin
          e2 = c[0];
        end
      end
    end
    if (e1 >= 0) g[e1] = 1'b1;
    if (e2 >= 0) g[e2] = 1'b1;
  endfunction

  task automatic step(input logic [1:0] av, input int i0, input int i1, input logic [N-1:0] rdy,
                      input logic r1, input logic r2, input logic fl);
    logic [N-1:0] g;
    int e1, e2, n_elig;
    @(negedge clk);
    alloc_valid = av; alloc_idx = {IW'(i1), IW'(i0)};
    entry_ready = rdy; alu1_rdy = r1; alu2_rdy = r2; flush = fl;
    model_grant(rdy, r1, r2, fl, g, e1, e2);
    n_elig = 0;
    foreach (age_q[k]) if (rdy[age_q[k]]) n_elig++;
    if (e1 >= 0) exp1_q.push_back(e1);
    if (e2 >= 0) exp2_q.push_back(e2);
    #1;
    chk("grant_vec", grant_vec, g);
    last_grant = grant_vec;
    @(posedge clk);
    if (fl) begin
      age_q.delete();
    end else begin
      if (n_elig > 0 && g == '0 && m_stall < 65535) m_stall++;
      for (int e = 0; e < N; e++) if (g[e]) drop(e);
      if (av[0]) begin
        if (held(i0)) m_err = 1'b1; else age_q.push_back(i0);
      end
      if (av[1]) begin
        if ((av[0] && i1 == i0) || held(i1)) m_err = 1'b1; else age_q.push_back(i1);
      end
    end
    #1;
    chk("stall_cnt", stall_cnt, m_stall);
    chk("proto_err", proto_err, m_err);
  endtask

  // Monitor: every registered issue must match the next scoreboard entry for that ALU.
  always @(posedge clk) begin
    #1;
    if (issue_valid[0]) begin
      if (exp1_q.size() == 0) flag("alu1_unexpected_issue");
      else chk("alu1_issue_idx", issue_idx[IW-1:0], exp1_q.pop_front());
    end else if (exp1_q.size() > 0) begin
      flag("alu1_missing_issue");
      void'(exp1_q.pop_front());
    end
    if (issue_valid[1]) begin
      if (exp2_q.size() == 0) flag("alu2_unexpected_issue");
      else chk("alu2_issue_idx", issue_idx[2*IW-1:IW], exp2_q.pop_front());
    end else if (exp2_q.size() > 0) begin
      flag("alu2_missing_issue");
      void'(exp2_q.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; alloc_valid = '0; alloc_idx = '0;
    entry_ready = '0; alu1_rdy = 1'b0; alu2_rdy = 1'b0;
    #1;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_idx", issue_idx, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_grant", grant_vec, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Age order: 5, 2, 7
    step(2'b01, 5, 0, 8'h00, 0, 0, 0);
    step(2'b01, 2, 0, 8'h00, 0, 0, 0);
    step(2'b01, 7, 0, 8'h00, 0, 0, 0);
    step(2'b00, 0, 0, 8'hFF, 1, 1, 0);
    chk("age_grant0", last_grant, 8'h24);
    chk("age_issue_valid", issue_valid, 2'b11);
    chk("age_issue_idx", issue_idx, {3'd2, 3'd5});
    step(2'b00, 0, 0, 8'hFF, 1, 1, 0);
    chk("age_grant1", last_grant, 8'h80);

    // Dual allocation ordering
    step(2'b11, 3, 1, 8'h00, 0, 0, 0);
    step(2'b00, 0, 0, 8'h0A, 0, 1, 0);
    chk("dual_grant0", last_grant, 8'h08);
    step(2'b00, 0, 0, 8'h0A, 0, 1, 0);
    chk("dual_grant1", last_grant, 8'h02);

    // Random traffic, always protocol-legal
    for (int t = 0; t < 800; t++) begin
      logic [N-1:0] rdy, g;
      logic r1, r2, fl;
      logic [1:0] av;
      int e1, e2, k0, k1, i0, i1;
      int cand[$];
      rdy = N'($urandom);
      r1  = ($urandom % 4) != 0;
      r2  = ($urandom % 4) != 0;
      fl  = ($urandom % 50) == 0;
      model_grant(rdy, r1, r2, fl, g, e1, e2);
      cand.delete();
      for (int e = 0; e < N; e++) if (!held(e) || g[e]) cand.push_back(e);
      av = 2'($urandom);
      i0 = 0; i1 = 0;
      if (cand.size() < 2) av[1] = 1'b0;
      if (cand.size() == 0) av = 2'b00;
      if (cand.size() > 0) begin
        k0 = $urandom_range(cand.size() - 1, 0);
        i0 = cand[k0];
        if (cand.size() > 1) begin
          k1 = (k0 + 1 + $urandom_range(cand.size() - 2, 0)) % cand.size();
          i1 = cand[k1];
        end
      end
      step(av, i0, i1, rdy, r1, r2, fl);
    end

    // Flush with four ready entries
    step(2'b00, 0, 0, 8'h00, 0, 0, 1);
    step(2'b11, 0, 1, 8'h00, 0, 0, 0);
    step(2'b11, 2, 3, 8'h00, 0, 0, 0);
    step(2'b00, 0, 0, 8'hFF, 1, 1, 1);
    chk("flush_grant", last_grant, 8'h00);
    chk("flush_issue_valid", issue_valid, 2'b00);
    step(2'b00, 0, 0, 8'hFF, 1, 1, 0);
    chk("flush_empty_grant", last_grant, 8'h00);

    // Stall counter saturation
    step(2'b01, 3, 0, 8'h00, 0, 0, 0);
    for (int t = 0; t < 70000; t++) step(2'b00, 0, 0, 8'h08, 0, 0, 0);
    chk("stall_saturated", stall_cnt, 16'hFFFF);
    step(2'b00, 0, 0, 8'h00, 0, 0, 1);
    chk("proto_clear", proto_err, 0);

    // Protocol errors: occupied entry 4 and duplicate index 6
    step(2'b01, 4, 0, 8'h00, 0, 0, 0);
    step(2'b01, 0, 0, 8'h00, 0, 0, 0);
    step(2'b01, 4, 0, 8'h00, 0, 0, 0);
    chk("proto_set", proto_err, 1);
    step(2'b11, 6, 6, 8'h00, 0, 0, 0);
    step(2'b00, 0, 0, 8'hFF, 1, 1, 0);
    chk("proto_age_grant", last_grant, 8'h11);
    chk("proto_age_issue", issue_idx, {3'd0, 3'd4});
    step(2'b00, 0, 0, 8'h00, 0, 0, 1);
    step(2'b00, 0, 0, 8'h00, 0, 0, 0);
    chk("proto_sticky", proto_err, 1);

    // Reset mid-operation with a full RS
    step(2'b11, 0, 1, 8'h00, 0, 0, 0);
    step(2'b11, 2, 3, 8'h00, 0, 0, 0);
    step(2'b11, 4, 5, 8'h00, 0, 0, 0);
    step(2'b11, 6, 7, 8'h00, 0, 0, 0);
    step(2'b11, 0, 1, 8'hFF, 1, 1, 0);
    chk("full_regrant", last_grant, 8'h03);
    chk("full_issue_valid", issue_valid, 2'b11);
    if (exp1_q.size() != 0 || exp2_q.size() != 0) flag("scoreboard_not_drained");
    #1;
    alloc_valid = '0;
    reset = 1'b1;
    #1;
    chk("async_rst_issue_valid", issue_valid, 0);
    chk("async_rst_issue_idx", issue_idx, 0);
    chk("async_rst_stall", stall_cnt, 0);
    chk("async_rst_proto", proto_err, 0);
    chk("async_rst_grant", grant_vec, 0);
    age_q.delete(); exp1_q.delete(); exp2_q.delete();
    m_stall = 0; m_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(2'b00, 0, 0, 8'hFF, 1, 1, 0);
    chk("post_rst_grant", last_grant, 8'h00);
    step(2'b00, 0, 0, 8'h00, 0, 0, 0);
    if (exp1_q.size() != 0 || exp2_q.size() != 0) flag("scoreboard_leftover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
